uart_tx_frame: RTL and testbench

UART transmitter that serialises one byte per handshake onto `uart_txd` as an 8N1/8E1/8O1/8x2 frame, LSB first, at a fixed baud derived from the system clock. It is the sending end of the board's serial link, driven by the same 50 MHz `sys_clk` and the same baud parameters as the receive path, so loopback of `uart_txd` into the receiver reproduces the byte.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_tx_frame_if.sv | 25 ++
 rtl/uart_baud_cnt.sv | 29 ++
 rtl/uart_tx_frame.sv | 124 ++++++++++++
 tb/tb_uart_tx_frame.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, parity codes, bit-period helper.
// Common to the transmit and receive paths.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_tx_state_t;

  localparam int UART_PAR_NONE = 0;
  localparam int UART_PAR_ODD  = 1;
  localparam int UART_PAR_EVEN = 2;

  function automatic int uart_bps_cnt(
    input int clk_fre,
    input int bps
  );
    return clk_fre / bps;
  endfunction

endpackage

// File: rtl/uart_tx_frame_if.sv
// Byte handshake between a UART transmit client and the transmitter.
// master drives the byte, slave reports ready/busy/done.
interface uart_tx_frame_if;
  logic       uart_tx_en;
  logic [7:0] uart_tx_data;
  logic       uart_tx_ready;
  logic       uart_tx_busy;
  logic       uart_tx_done;

  modport master (
    output uart_tx_en,
    output uart_tx_data,
    input  uart_tx_ready,
    input  uart_tx_busy,
    input  uart_tx_done
  );

  modport slave (
    input  uart_tx_en,
    input  uart_tx_data,
    output uart_tx_ready,
    output uart_tx_busy,
    output uart_tx_done
  );
endinterface

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: tick marks the last cycle of each bit period.
// Holds at zero while run is low; clear restarts the period.
module uart_baud_cnt #(
  parameter int CNT = 434
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic run,
  input  logic clear,
  output logic tick
);

  localparam int W = (CNT > 1) ? $clog2(CNT) : 1;

  logic [W-1:0] cnt;

  assign tick = run && (cnt == W'(CNT - 1));

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: one byte per handshake, LSB first,
// optional parity, one or two stop bits.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int BPS         = 115200,
  parameter int SYS_CLK_FRE = 50_000_000,
  parameter int PARITY      = UART_PAR_NONE,
  parameter int STOP_BITS   = 1
) (
  input  logic            sys_clk,
  input  logic            sys_rst,
  uart_tx_frame_if.slave  tx,
  output logic            uart_txd
);

  localparam int BPS_CNT = uart_bps_cnt(SYS_CLK_FRE, BPS);

  uart_tx_state_t state;
  logic [7:0]     shreg;
  logic [2:0]     bit_idx;
  logic           stop_idx;
  logic           par_q;
  logic           busy_q;
  logic           done_q;
  logic           tick;
  logic           accept;
  logic           par_in;

  assign accept = tx.uart_tx_en && !busy_q;

  assign par_in = (PARITY == UART_PAR_EVEN) ?
                  (^tx.uart_tx_data) :
                  (~^tx.uart_tx_data);

  assign tx.uart_tx_ready = !busy_q;
  assign tx.uart_tx_busy  = busy_q;
  assign tx.uart_tx_done  = done_q;

  uart_baud_cnt #(
    .CNT (BPS_CNT)
  ) u_baud (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .run     (busy_q),
    .clear   (accept),
    .tick    (tick)
  );

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state    <= ST_IDLE;
      shreg    <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      par_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      uart_txd <= 1'b1;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          uart_txd <= 1'b1;
          if (accept) begin
            shreg    <= tx.uart_tx_data;
            par_q    <= par_in;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            busy_q   <= 1'b1;
            uart_txd <= 1'b0;
            state    <= ST_START;
          end
        end
        ST_START: begin
          if (tick) begin
            uart_txd <= shreg[0];
            state    <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (bit_idx == 3'd7) begin
              if (PARITY != UART_PAR_NONE) begin
                uart_txd <= par_q;
                state    <= ST_PARITY;
              end else begin
                uart_txd <= 1'b1;
                state    <= ST_STOP;
              end
            end else begin
              bit_idx  <= bit_idx + 3'd1;
              uart_txd <= shreg[1];
              shreg    <= {1'b0, shreg[7:1]};
            end
          end
        end
        ST_PARITY: begin
          if (tick) begin
            uart_txd <= 1'b1;
            state    <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (tick) begin
            if (stop_idx == 1'(STOP_BITS - 1)) begin
              busy_q <= 1'b0;
              done_q <= 1'b1;
              state  <= ST_IDLE;
            end else begin
              stop_idx <= stop_idx + 1'b1;
            end
          end
        end
        default: begin
          uart_txd <= 1'b1;
          busy_q   <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench: 8N1, 8E1, 8O1 and 8N2 transmitters
// at a 10-cycle bit period, checked sample by sample.
module tb_uart_tx_frame;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic [3:0] en      = 4'h0;
  logic [7:0] data    = 8'h00;
  wire  [3:0] txd;
  wire  [3:0] rdy;
  wire  [3:0] bsy;
  wire  [3:0] dn;

  int nchk  = 0;
  int nfail = 0;

  always #5 sys_clk = ~sys_clk;

  uart_tx_frame_if if0 ();
  uart_tx_frame_if if1 ();
  uart_tx_frame_if if2 ();
  uart_tx_frame_if if3 ();

  assign if0.uart_tx_en   = en[0];
  assign if1.uart_tx_en   = en[1];
  assign if2.uart_tx_en   = en[2];
  assign if3.uart_tx_en   = en[3];
  assign if0.uart_tx_data = data;
  assign if1.uart_tx_data = data;
  assign if2.uart_tx_data = data;
  assign if3.uart_tx_data = data;

  assign rdy = {if3.uart_tx_ready, if2.uart_tx_ready,
                if1.uart_tx_ready, if0.uart_tx_ready};
  assign bsy = {if3.uart_tx_busy, if2.uart_tx_busy,
                if1.uart_tx_busy, if0.uart_tx_busy};
  assign dn  = {if3.uart_tx_done, if2.uart_tx_done,
                if1.uart_tx_done, if0.uart_tx_done};

  uart_tx_frame #(.BPS(100), .SYS_CLK_FRE(1000),
    .PARITY(0), .STOP_BITS(1)) u_n1 (
    .sys_clk (sys_clk), .sys_rst (sys_rst),
    .tx (if0), .uart_txd (txd[0]));

  uart_tx_frame #(.BPS(100), .SYS_CLK_FRE(1000),
    .PARITY(2), .STOP_BITS(1)) u_e1 (
    .sys_clk (sys_clk), .sys_rst (sys_rst),
    .tx (if1), .uart_txd (txd[1]));

  uart_tx_frame #(.BPS(100), .SYS_CLK_FRE(1000),
    .PARITY(1), .STOP_BITS(1)) u_o1 (
    .sys_clk (sys_clk), .sys_rst (sys_rst),
    .tx (if2), .uart_txd (txd[2]));

  uart_tx_frame #(.BPS(100), .SYS_CLK_FRE(1000),
    .PARITY(0), .STOP_BITS(2)) u_n2 (
    .sys_clk (sys_clk), .sys_rst (sys_rst),
    .tx (if3), .uart_txd (txd[3]));

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Returns at the negedge just after the accept edge.
  task automatic send(input int k, input logic [7:0] b);
    @(negedge sys_clk);
    data  = b;
    en[k] = 1'b1;
    @(negedge sys_clk);
    en[k] = 1'b0;
  endtask

  // Sample 0 is the negedge after the accept edge; returns on
  // the done sample (index len) without advancing further.
  task automatic check_frame(input string tag, input int k,
                             input logic [7:0] d,
                             input int pm, input int stops);
    int   nbits;
    int   len;
    int   errs;
    int   first_dn;
    int   ndn;
    logic rdy_at_dn;
    logic pbit;
    logic e;
    int   b;
    nbits     = 9 + ((pm != 0) ? 1 : 0) + stops;
    len       = nbits * 10;
    errs      = 0;
    first_dn  = -1;
    ndn       = 0;
    rdy_at_dn = 1'b0;
    pbit      = ($countones(d) % 2) == 1;
    if (pm == 1) pbit = ~pbit;
    for (int i = 0; i <= len; i++) begin
      b = i / 10;
      if (i == len)               e = 1'b1;
      else if (b == 0)            e = 1'b0;
      else if (b <= 8)            e = d[b-1];
      else if (b == 9 && pm != 0) e = pbit;
      else                        e = 1'b1;
      if (txd[k] !== e) errs++;
      if (i < len && bsy[k] !== 1'b1) errs++;
      if (dn[k] === 1'b1) begin
        ndn++;
        if (first_dn < 0) begin
          first_dn  = i;
          rdy_at_dn = rdy[k];
        end
      end
      if (i < len) @(negedge sys_clk);
    end
    check({tag, "_line"}, errs, 0);
    check({tag, "_done_at"}, first_dn, len);
    check({tag, "_done_n"}, ndn, 1);
    check({tag, "_rdy_done"}, {31'd0, rdy_at_dn}, 1);
  endtask

  int lows;

  initial begin
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;
    @(negedge sys_clk);
    check("rst_txd", {28'd0, txd}, 32'hF);
    check("rst_rdy", {28'd0, rdy}, 32'hF);
    check("rst_bsy", {28'd0, bsy}, 32'h0);
    check("rst_dn",  {28'd0, dn},  32'h0);

    send(0, 8'h55);
    check("acc_txd", {31'd0, txd[0]}, 0);
    check("acc_bsy", {31'd0, bsy[0]}, 1);
    check("acc_rdy", {31'd0, rdy[0]}, 0);
    check_frame("n55", 0, 8'h55, 0, 1);

    send(1, 8'h07);
    check_frame("e07", 1, 8'h07, 2, 1);
    send(2, 8'h07);
    check_frame("o07", 2, 8'h07, 1, 1);

    // 8N2 with en held high: second byte goes out right after done
    @(negedge sys_clk);
    data  = 8'hA3;
    en[3] = 1'b1;
    @(negedge sys_clk);
    data  = 8'h3C;
    check_frame("a3", 3, 8'hA3, 0, 2);
    @(negedge sys_clk);
    en[3] = 1'b0;
    check("b2b_start", {31'd0, txd[3]}, 0);
    check_frame("b2b", 3, 8'h3C, 0, 2);

    // en pulsed with 0xFF mid-frame must be dropped
    send(0, 8'h00);
    fork
      check_frame("ign", 0, 8'h00, 0, 1);
      begin
        repeat (30) @(negedge sys_clk);
        data  = 8'hFF;
        en[0] = 1'b1;
        @(negedge sys_clk);
        en[0] = 1'b0;
      end
    join
    lows = 0;
    repeat (20) begin
      @(negedge sys_clk);
      if (txd[0] !== 1'b1) lows++;
    end
    check("ign_idle", lows, 0);

    @(negedge sys_clk);
    data  = 8'hC3;
    en[0] = 1'b1;
    @(negedge sys_clk);
    en[0] = 1'b0;
    data  = 8'h00;
    check_frame("c3", 0, 8'hC3, 0, 1);

    // reset during data bit 4 (low bit of 0x0F's upper nibble)
    send(0, 8'h0F);
    repeat (53) @(negedge sys_clk);
    check("pre_rst_txd", {31'd0, txd[0]}, 0);
    sys_rst = 1'b1;
    #1;
    check("rst_mid_txd", {31'd0, txd[0]}, 1);
    check("rst_mid_bsy", {31'd0, bsy[0]}, 0);
    check("rst_mid_rdy", {31'd0, rdy[0]}, 1);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    @(negedge sys_clk);
    send(0, 8'h12);
    check_frame("r12", 0, 8'h12, 0, 1);

    repeat (5) @(negedge sys_clk);
    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule
